// File: rtl/dmem_hs.sv
// Single-port byte-addressable data memory with a valid/ready request port and RD_LAT-cycle response.
// Optional sticky fault latch (err_clr/err_flag/err_addr) is enabled by defining DMEM_ERR_LATCH_EN.
module dmem_hs #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 64,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned RD_LAT = 1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
`ifdef DMEM_ERR_LATCH_EN
    input  logic              err_clr,
    output logic              err_flag,
    output logic [ADDR_W-1:0] err_addr,
`endif
    output logic              rsp_err
);

    localparam int unsigned NB       = DATA_W / 8;
    localparam int unsigned LANE_W   = $clog2(NB);
    localparam int unsigned IDX_W    = $clog2(DEPTH);
    localparam int unsigned HI_LSB   = LANE_W + IDX_W;
    localparam int unsigned BIT_W    = $clog2(DATA_W);
    localparam int unsigned CNT_W    = 2;
    localparam int unsigned CNT_INIT = (RD_LAT > 1) ? RD_LAT - 2 : 0;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(CNT_INIT);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t             state;
    state_t             next_state;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_nxt;
    logic               ready_nxt;
    logic               valid_nxt;

    logic [IDX_W-1:0]   idx;
    logic [LANE_W-1:0]  lane;
    logic [3:0]         nbytes;
    logic [6:0]         nbits;
    logic               size_big;
    logic               misalign;
    logic               out_range;
    logic               fault;
    logic               accept;
    logic               do_write;
    logic [DATA_W-1:0]  rd_word;
    logic [DATA_W-1:0]  rd_shift;
    logic [DATA_W-1:0]  ld_mask;
    logic [DATA_W-1:0]  ld_data;
    logic [DATA_W-1:0]  wr_shift;
    logic [BIT_W-1:0]   sign_idx;
    logic               sign;

    // Request decode, fault detection and load-data extraction at the accept edge
    always_comb begin : decode
        idx       = req_addr[LANE_W +: IDX_W];
        lane      = req_addr[LANE_W-1:0];
        nbytes    = 4'd1 << req_size;
        nbits     = {nbytes, 3'b000};
        size_big  = 32'(nbytes) > NB;
        misalign  = (req_addr[2:0] & 3'(nbytes - 4'd1)) != 3'd0;
        out_range = (req_addr >> HI_LSB) != '0;
        fault     = size_big | misalign | out_range;
        accept    = req_valid & req_ready;
        do_write  = accept & req_we & ~fault;
        rd_shift  = rd_word >> {lane, 3'b000};
        ld_mask   = (32'(nbits) >= DATA_W) ? '1 : ((DATA_W'(1) << nbits) - DATA_W'(1));
        sign_idx  = BIT_W'(nbits - 7'd1);
        sign      = rd_shift[sign_idx] & ~req_unsigned;
        ld_data   = (rd_shift & ld_mask) | (sign ? ~ld_mask : '0);
        if (req_we || fault) begin
            ld_data = '0;
        end
        wr_shift  = req_wdata << {lane, 3'b000};
    end

    // One byte-wide array per lane so each lane has its own write enable
    for (genvar b = 0; b < NB; b++) begin : g_lane
        logic [7:0] lane_mem [DEPTH];
        logic       lane_we;

        assign lane_we = do_write && (32'(b) >= 32'(lane)) && (32'(b) < 32'(lane) + 32'(nbytes));
        assign rd_word[b*8 +: 8] = lane_mem[idx];

        always_ff @(posedge CLK or posedge RST) begin : lane_store
            if (RST) begin
                for (int unsigned i = 0; i < DEPTH; i++) begin
                    lane_mem[IDX_W'(i)] <= '0;
                end
            end else if (lane_we) begin
                lane_mem[idx] <= wr_shift[b*8 +: 8];
            end
        end
    end

    // State register plus registered outputs
    always_ff @(posedge CLK or posedge RST) begin : state_reg
        if (RST) begin
            state     <= S_IDLE;
            cnt       <= '0;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            state     <= next_state;
            cnt       <= cnt_nxt;
            req_ready <= ready_nxt;
            rsp_valid <= valid_nxt;
            if (accept) begin
                rsp_rdata <= ld_data;
                rsp_err   <= fault;
            end
        end
    end

    // Next-state logic; WAIT lasts RD_LAT-1 cycles
    always_comb begin : next_state_logic
        next_state = state;
        cnt_nxt    = cnt;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    if (RD_LAT == 1) begin
                        next_state = S_RESP;
                    end else begin
                        next_state = S_WAIT;
                        cnt_nxt    = CNT_LOAD;
                    end
                end
            end
            S_WAIT: begin
                if (cnt == '0) begin
                    next_state = S_RESP;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            S_RESP:  next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    // Output decode from the upcoming state, registered in state_reg
    always_comb begin : output_logic
        ready_nxt = 1'b0;
        valid_nxt = 1'b0;
        if (next_state == S_IDLE) begin
            ready_nxt = 1'b1;
        end
        if (next_state == S_RESP) begin
            valid_nxt = 1'b1;
        end
    end

`ifdef DMEM_ERR_LATCH_EN
    // Sticky first-fault latch; a fault in the clear cycle wins and is captured
    always_ff @(posedge CLK or posedge RST) begin : err_latch
        if (RST) begin
            err_flag <= 1'b0;
            err_addr <= '0;
        end else if (accept && fault && (!err_flag || err_clr)) begin
            err_flag <= 1'b1;
            err_addr <= req_addr;
        end else if (err_clr) begin
            err_flag <= 1'b0;
            err_addr <= '0;
        end
    end
`endif

endmodule

// File: tb/tb_dmem_hs.sv
// Self-checking bench for dmem_hs: four instances covering DATA_W {32,64} and RD_LAT {1,2,4}.
// Responses are checked against a scoreboard queue of expected {rdata, err}.
module tb_dmem_hs;

    localparam int unsigned NDUT = 4;

    logic CLK = 1'b0;
    logic RST;
    always #5 CLK = ~CLK;

    logic        req_valid_a    [NDUT];
    logic        req_ready_a    [NDUT];
    logic        req_we_a       [NDUT];
    logic [31:0] req_addr_a     [NDUT];
    logic [1:0]  req_size_a     [NDUT];
    logic        req_unsigned_a [NDUT];
    logic [63:0] req_wdata_a    [NDUT];
    logic        rsp_valid_a    [NDUT];
    logic [63:0] rsp_rdata_a    [NDUT];
    logic        rsp_err_a      [NDUT];
`ifdef DMEM_ERR_LATCH_EN
    logic        err_clr_a      [NDUT];
    logic        err_flag_a     [NDUT];
    logic [31:0] err_addr_a     [NDUT];
`endif

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        localparam int unsigned W = (g == 1 || g == 3) ? 64 : 32;
        localparam int unsigned L = (g == 0) ? 2 : (g == 1) ? 4 : 1;
        logic [W-1:0] rd;
        dmem_hs #(.DATA_W(W), .DEPTH(64), .ADDR_W(32), .RD_LAT(L)) u_dut (
            .CLK          (CLK),
            .RST          (RST),
            .req_valid    (req_valid_a[g]),
            .req_ready    (req_ready_a[g]),
            .req_we       (req_we_a[g]),
            .req_addr     (req_addr_a[g]),
            .req_size     (req_size_a[g]),
            .req_unsigned (req_unsigned_a[g]),
            .req_wdata    (W'(req_wdata_a[g])),
            .rsp_valid    (rsp_valid_a[g]),
            .rsp_rdata    (rd),
`ifdef DMEM_ERR_LATCH_EN
            .err_clr      (err_clr_a[g]),
            .err_flag     (err_flag_a[g]),
            .err_addr     (err_addr_a[g]),
`endif
            .rsp_err      (rsp_err_a[g])
        );
        assign rsp_rdata_a[g] = 64'(rd);
    end

    typedef struct {
        logic [63:0] rdata;
        logic        err;
    } exp_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [1:0]  size;
        logic        uns;
        logic [63:0] wdata;
        logic [63:0] exp;
        logic        err;
    } req_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    function automatic int lat_of(input int g);
        return (g == 0) ? 2 : (g == 1) ? 4 : 1;
    endfunction

    function automatic int width_of(input int g);
        return (g == 1 || g == 3) ? 64 : 32;
    endfunction

    // Drive one request, scramble inputs after accept, collect the response
    task automatic xact(input int g, input logic we, input logic [31:0] addr, input logic [1:0] size,
                        input logic uns, input logic [63:0] wdata,
                        output logic [63:0] rdata, output logic err, output int lat, output logic proto_ok);
        int n;
        rdata = '0; err = 1'b1; lat = -1; proto_ok = 1'b1; n = 0;
        @(negedge CLK);
        while (!req_ready_a[g] && n < 20) begin
            @(negedge CLK);
            n++;
        end
        req_valid_a[g] = 1'b1; req_we_a[g] = we; req_addr_a[g] = addr;
        req_size_a[g] = size; req_unsigned_a[g] = uns; req_wdata_a[g] = wdata;
        @(negedge CLK);
        req_valid_a[g] = 1'b0; req_we_a[g] = ~we; req_addr_a[g] = 32'hFFFF_FFFC;
        req_size_a[g] = 2'd0; req_unsigned_a[g] = ~uns; req_wdata_a[g] = '1;
        for (int k = 1; k <= 12; k++) begin
            if (rsp_valid_a[g]) begin
                rdata = rsp_rdata_a[g]; err = rsp_err_a[g]; lat = k;
                break;
            end
            if (req_ready_a[g]) proto_ok = 1'b0;
            @(negedge CLK);
        end
        @(negedge CLK);
        if (rsp_valid_a[g] || !req_ready_a[g]) proto_ok = 1'b0;
    endtask

    task automatic test_reset();
        logic [63:0] rd; logic er, ok; int lat; exp_t e;
        RST = 1'b1;
        repeat (2) @(negedge CLK);
        for (int g = 0; g < NDUT; g++) begin
            checks++;
            if (req_ready_a[g] !== 1'b1 || rsp_valid_a[g] !== 1'b0 || rsp_rdata_a[g] !== '0 || rsp_err_a[g] !== 1'b0) begin
                errors++;
                $display("FAIL reset_state dut%0d: ready=%b valid=%b rdata=%h err=%b, expected 1 0 0 0",
                         g, req_ready_a[g], rsp_valid_a[g], rsp_rdata_a[g], rsp_err_a[g]);
            end
        end
        #2 RST = 1'b0;
        sb_q.push_back('{64'h0, 1'b0});
        xact(0, 1'b0, 32'h0, 2'd2, 1'b0, '0, rd, er, lat, ok);
        e = sb_q.pop_front();
        checks++;
        if (rd !== e.rdata || er !== e.err || lat != lat_of(0)) begin
            errors++;
            $display("FAIL reset_load0: rdata=%h err=%b lat=%0d, expected %h %b %0d", rd, er, lat, e.rdata, e.err, lat_of(0));
        end
    endtask

    task automatic test_store_load();
        req_t tbl[$]; logic [63:0] rd; logic er, ok; int lat; exp_t e;
        tbl.push_back('{1'b1, 32'h10, 2'd2, 1'b0, 64'hDEAD_BEEF, 64'h0,         1'b0});
        tbl.push_back('{1'b0, 32'h10, 2'd2, 1'b0, 64'h0,         64'hDEAD_BEEF, 1'b0});
        foreach (tbl[i]) begin
            sb_q.push_back('{tbl[i].exp, tbl[i].err});
            xact(0, tbl[i].we, tbl[i].addr, tbl[i].size, tbl[i].uns, tbl[i].wdata, rd, er, lat, ok);
            e = sb_q.pop_front();
            checks++;
            if (rd !== e.rdata || er !== e.err) begin
                errors++;
                $display("FAIL store_load[%0d]: rdata=%h err=%b, expected %h %b", i, rd, er, e.rdata, e.err);
            end
            checks++;
            if (lat != 2 || !ok) begin
                errors++;
                $display("FAIL store_load_timing[%0d]: lat=%0d proto_ok=%b, expected 2 1", i, lat, ok);
            end
        end
    endtask

    task automatic test_subword();
        req_t tbl[$]; logic [63:0] rd; logic er, ok; int lat; exp_t e;
        tbl.push_back('{1'b1, 32'h11, 2'd0, 1'b0, 64'h80,   64'h0,         1'b0});
        tbl.push_back('{1'b0, 32'h11, 2'd0, 1'b0, 64'h0,    64'hFFFF_FF80, 1'b0});
        tbl.push_back('{1'b0, 32'h11, 2'd0, 1'b1, 64'h0,    64'h0000_0080, 1'b0});
        tbl.push_back('{1'b0, 32'h10, 2'd2, 1'b0, 64'h0,    64'hDEAD_80EF, 1'b0});
        tbl.push_back('{1'b1, 32'h12, 2'd1, 1'b0, 64'h1234, 64'h0,         1'b0});
        tbl.push_back('{1'b0, 32'h10, 2'd2, 1'b0, 64'h0,    64'h1234_80EF, 1'b0});
        tbl.push_back('{1'b0, 32'h10, 2'd1, 1'b0, 64'h0,    64'hFFFF_80EF, 1'b0});
        tbl.push_back('{1'b0, 32'h12, 2'd1, 1'b0, 64'h0,    64'h0000_1234, 1'b0});
        foreach (tbl[i]) begin
            sb_q.push_back('{tbl[i].exp, tbl[i].err});
            xact(0, tbl[i].we, tbl[i].addr, tbl[i].size, tbl[i].uns, tbl[i].wdata, rd, er, lat, ok);
            e = sb_q.pop_front();
            checks++;
            if (rd !== e.rdata || er !== e.err || lat != 2) begin
                errors++;
                $display("FAIL subword[%0d]: rdata=%h err=%b lat=%0d, expected %h %b 2", i, rd, er, lat, e.rdata, e.err);
            end
        end
    endtask

    task automatic test_faults();
        req_t tbl[$]; logic [63:0] rd; logic er, ok; int lat; exp_t e;
        tbl.push_back('{1'b0, 32'h13,  2'd2, 1'b0, 64'h0,   64'h0,         1'b1});
        tbl.push_back('{1'b0, 32'h100, 2'd2, 1'b0, 64'h0,   64'h0,         1'b1});
        tbl.push_back('{1'b1, 32'h10,  2'd3, 1'b0, '1,      64'h0,         1'b1});
        tbl.push_back('{1'b1, 32'h100, 2'd2, 1'b0, 64'hAAAA_AAAA, 64'h0,   1'b1});
        tbl.push_back('{1'b1, 32'h11,  2'd1, 1'b0, 64'hBBBB, 64'h0,        1'b1});
        tbl.push_back('{1'b0, 32'h0,   2'd2, 1'b0, 64'h0,   64'h0,         1'b0});
        tbl.push_back('{1'b0, 32'h10,  2'd2, 1'b0, 64'h0,   64'h1234_80EF, 1'b0});
        tbl.push_back('{1'b1, 32'h13,  2'd0, 1'b0, 64'h55,  64'h0,         1'b0});
        tbl.push_back('{1'b0, 32'h10,  2'd2, 1'b0, 64'h0,   64'h5534_80EF, 1'b0});
        foreach (tbl[i]) begin
            sb_q.push_back('{tbl[i].exp, tbl[i].err});
            xact(0, tbl[i].we, tbl[i].addr, tbl[i].size, tbl[i].uns, tbl[i].wdata, rd, er, lat, ok);
            e = sb_q.pop_front();
            checks++;
            if (rd !== e.rdata || er !== e.err || lat != 2) begin
                errors++;
                $display("FAIL faults[%0d]: rdata=%h err=%b lat=%0d, expected %h %b 2", i, rd, er, lat, e.rdata, e.err);
            end
        end
    endtask

`ifdef DMEM_ERR_LATCH_EN
    task automatic test_err_latch();
        checks++;
        if (err_flag_a[0] !== 1'b1 || err_addr_a[0] !== 32'h13) begin
            errors++;
            $display("FAIL err_first: flag=%b addr=%h, expected 1 00000013", err_flag_a[0], err_addr_a[0]);
        end
        @(negedge CLK);
        err_clr_a[0] = 1'b1;
        req_valid_a[0] = 1'b1; req_we_a[0] = 1'b0; req_addr_a[0] = 32'h21; req_size_a[0] = 2'd2;
        @(negedge CLK);
        err_clr_a[0] = 1'b0; req_valid_a[0] = 1'b0;
        checks++;
        if (err_flag_a[0] !== 1'b1 || err_addr_a[0] !== 32'h21) begin
            errors++;
            $display("FAIL err_fault_wins: flag=%b addr=%h, expected 1 00000021", err_flag_a[0], err_addr_a[0]);
        end
        repeat (3) @(negedge CLK);
        err_clr_a[0] = 1'b1;
        @(negedge CLK);
        err_clr_a[0] = 1'b0;
        checks++;
        if (err_flag_a[0] !== 1'b0 || err_addr_a[0] !== 32'h0) begin
            errors++;
            $display("FAIL err_clear: flag=%b addr=%h, expected 0 00000000", err_flag_a[0], err_addr_a[0]);
        end
    endtask
`endif

    // Hold a load request for 'hold' cycles and count accepts/responses
    task automatic run_held(input int hold, output int accepts, output int resps);
        exp_t e;
        accepts = 0; resps = 0;
        @(negedge CLK);
        req_valid_a[0] = 1'b1; req_we_a[0] = 1'b0; req_addr_a[0] = 32'h10;
        req_size_a[0] = 2'd2; req_unsigned_a[0] = 1'b0;
        for (int k = 0; k < hold + 6; k++) begin
            if (k == hold) req_valid_a[0] = 1'b0;
            if (req_valid_a[0] && req_ready_a[0]) begin
                accepts++;
                sb_q.push_back('{64'h5534_80EF, 1'b0});
            end
            if (rsp_valid_a[0]) begin
                resps++;
                checks++;
                if (sb_q.size() == 0) begin
                    errors++;
                    $display("FAIL held_resp: unexpected response rdata=%h, expected none", rsp_rdata_a[0]);
                end else begin
                    e = sb_q.pop_front();
                    if (rsp_rdata_a[0] !== e.rdata || rsp_err_a[0] !== e.err) begin
                        errors++;
                        $display("FAIL held_resp: rdata=%h err=%b, expected %h %b", rsp_rdata_a[0], rsp_err_a[0], e.rdata, e.err);
                    end
                end
            end
            @(negedge CLK);
        end
        sb_q.delete();
    endtask

    task automatic test_busy();
        int acc, rsp;
        run_held(3, acc, rsp);
        checks++;
        if (acc != 1 || rsp != 1) begin
            errors++;
            $display("FAIL busy_ignore: accepts=%0d responses=%0d, expected 1 1", acc, rsp);
        end
    endtask

    task automatic test_back_to_back();
        int acc, rsp;
        run_held(9, acc, rsp);
        checks++;
        if (acc != 3 || rsp != 3) begin
            errors++;
            $display("FAIL back_to_back: accepts=%0d responses=%0d, expected 3 3", acc, rsp);
        end
    endtask

    task automatic test_reset_midop();
        logic [63:0] rd; logic er, ok; int lat; logic seen;
        xact(0, 1'b1, 32'h20, 2'd2, 1'b0, 64'hCAFE_F00D, rd, er, lat, ok);
        @(negedge CLK);
        req_valid_a[0] = 1'b1; req_we_a[0] = 1'b0; req_addr_a[0] = 32'h20; req_size_a[0] = 2'd2;
        @(posedge CLK);
        #2 RST = 1'b1;
        #1;
        checks++;
        if (req_ready_a[0] !== 1'b1 || rsp_valid_a[0] !== 1'b0) begin
            errors++;
            $display("FAIL reset_async: ready=%b valid=%b, expected 1 0", req_ready_a[0], rsp_valid_a[0]);
        end
        @(negedge CLK);
        req_valid_a[0] = 1'b0;
        @(negedge CLK);
        RST = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 6; k++) begin
            if (rsp_valid_a[0]) seen = 1'b1;
            @(negedge CLK);
        end
        checks++;
        if (seen || req_ready_a[0] !== 1'b1) begin
            errors++;
            $display("FAIL reset_drop: rsp_seen=%b ready=%b, expected 0 1", seen, req_ready_a[0]);
        end
        xact(0, 1'b0, 32'h20, 2'd2, 1'b0, '0, rd, er, lat, ok);
        checks++;
        if (rd !== 64'h0 || er !== 1'b0) begin
            errors++;
            $display("FAIL reset_cleared: rdata=%h err=%b, expected 0 0", rd, er);
        end
    endtask

    task automatic test_sweep();
        logic [63:0] rd, d; logic er, ok; int lat; exp_t e; int bytes; logic [1:0] sz;
        for (int g = 0; g < NDUT; g++) begin
            bytes = width_of(g) / 8;
            sz = (bytes == 8) ? 2'd3 : 2'd2;
            for (int i = 0; i < 64; i++) begin
                d = (bytes == 8) ? {32'hA5A5_0000 | 32'(i), 32'(i)} : 64'(32'h5A5A_0000 | 32'(i));
                xact(g, 1'b1, 32'(i * bytes), sz, 1'b0, d, rd, er, lat, ok);
                checks++;
                if (er !== 1'b0 || lat != lat_of(g) || !ok) begin
                    errors++;
                    $display("FAIL sweep_wr dut%0d[%0d]: err=%b lat=%0d ok=%b, expected 0 %0d 1", g, i, er, lat, ok, lat_of(g));
                end
            end
            for (int i = 0; i < 64; i++) begin
                d = (bytes == 8) ? {32'hA5A5_0000 | 32'(i), 32'(i)} : 64'(32'h5A5A_0000 | 32'(i));
                sb_q.push_back('{d, 1'b0});
                xact(g, 1'b0, 32'(i * bytes), sz, 1'b1, '0, rd, er, lat, ok);
                e = sb_q.pop_front();
                checks++;
                if (rd !== e.rdata || er !== e.err || lat != lat_of(g) || !ok) begin
                    errors++;
                    $display("FAIL sweep_rd dut%0d[%0d]: rdata=%h err=%b lat=%0d, expected %h %b %0d",
                             g, i, rd, er, lat, e.rdata, e.err, lat_of(g));
                end
            end
        end
    endtask

    task automatic test_wide();
        req_t tbl[$]; logic [63:0] rd; logic er, ok; int lat; exp_t e;
        tbl.push_back('{1'b0, 32'h14,  2'd2, 1'b0, 64'h0,  64'hFFFF_FFFF_A5A5_0002, 1'b0});
        tbl.push_back('{1'b0, 32'h14,  2'd2, 1'b1, 64'h0,  64'h0000_0000_A5A5_0002, 1'b0});
        tbl.push_back('{1'b0, 32'h17,  2'd0, 1'b0, 64'h0,  64'hFFFF_FFFF_FFFF_FFA5, 1'b0});
        tbl.push_back('{1'b0, 32'h10,  2'd1, 1'b0, 64'h0,  64'h0000_0000_0000_0002, 1'b0});
        tbl.push_back('{1'b0, 32'h14,  2'd3, 1'b0, 64'h0,  64'h0,                   1'b1});
        tbl.push_back('{1'b0, 32'h200, 2'd3, 1'b0, 64'h0,  64'h0,                   1'b1});
        tbl.push_back('{1'b1, 32'h11,  2'd0, 1'b0, 64'h99, 64'h0,                   1'b0});
        tbl.push_back('{1'b0, 32'h10,  2'd3, 1'b0, 64'h0,  64'hA5A5_0002_0000_9902, 1'b0});
        foreach (tbl[i]) begin
            sb_q.push_back('{tbl[i].exp, tbl[i].err});
            xact(1, tbl[i].we, tbl[i].addr, tbl[i].size, tbl[i].uns, tbl[i].wdata, rd, er, lat, ok);
            e = sb_q.pop_front();
            checks++;
            if (rd !== e.rdata || er !== e.err || lat != 4) begin
                errors++;
                $display("FAIL wide[%0d]: rdata=%h err=%b lat=%0d, expected %h %b 4", i, rd, er, lat, e.rdata, e.err);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached before completion, expected summary");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int g = 0; g < NDUT; g++) begin
            req_valid_a[g] = 1'b0; req_we_a[g] = 1'b0; req_addr_a[g] = '0;
            req_size_a[g] = 2'd0; req_unsigned_a[g] = 1'b0; req_wdata_a[g] = '0;
`ifdef DMEM_ERR_LATCH_EN
            err_clr_a[g] = 1'b0;
`endif
        end
        test_reset();
        test_store_load();
        test_subword();
        test_faults();
`ifdef DMEM_ERR_LATCH_EN
        test_err_latch();
`endif
        test_busy();
        test_back_to_back();
        test_reset_midop();
        test_sweep();
        test_wide();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
